return_addr_stack: RTL
======================

# return_addr_stack

Hardware return-address stack that executes the push/pop requests issued by the ID-stage control unit for CALL (opcode 000011) and RET (opcode 000001). Return addresses are stored in a circular LIFO, and the stack applies an operation only on the instruction commit strobe (PCWrite). The IF-stage PC mux reads `top_addr` as the RET target. Overflow and underflow are tracked with sticky error flags.

## Interface
- `ADDR_WIDTH`, 32: width of a stored return address (PC width).
- `DEPTH`, 8: number of entries; power of two, minimum 2.

- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted at 0).
- `push`  input  1  level from control decode; CALL in flight.
- `pop`  input  1  level from control decode; RET in flight.
- `commit`  input  1  one-cycle commit strobe (control PCWrite); qualifies push/pop.
- `push_addr`  input  ADDR_WIDTH  return address to store (PC+1 of the CALL).
- `clear_err`  input  1  synchronous clear of `overflow`/`underflow`.
- `top_addr`  output  ADDR_WIDTH  current top entry; 0 when empty.
- `empty`  output  1  count == 0.
- `full`  output  1  count == DEPTH.
- `count`  output  $clog2(DEPTH)+1  number of valid entries.
- `overflow`  output  1  sticky; set when a push occurred while full.
- `underflow`  output  1  sticky; set when a pop occurred while empty.

## Operation
- State consists of the write pointer `wp` ($clog2(DEPTH) bits, wraps modulo DEPTH), `count`, two sticky flags, and the DEPTH×ADDR_WIDTH storage.
- `push`/`pop` are ignored unless `commit`=1. The control unit holds these signals for all five stages, so each instruction is applied exactly once.
- `commit`=1 with `push`=0 and `pop`=0: no change.
- Push only, not full: `mem[wp]<=push_addr`, `wp<=wp+1`, `count<=count+1`.
- Push only, full: circular overwrite of the oldest entry. Write `mem[wp]`, `wp<=wp+1`, `count` stays DEPTH, `overflow<=1`.
- Pop only, not empty: `wp<=wp-1`, `count<=count-1`. Stored data is not cleared.
- Pop only, empty: no pointer or count change, `underflow<=1`.
- Push and pop together, not empty: replace the top entry (tail call). `mem[wp-1]<=push_addr`; `wp` and `count` unchanged.
- Push and pop together, empty: acts as push only, `underflow<=1`.
- `top_addr` is `mem[wp-1]` when `count`≠0, else 0. It is a combinational read of the registered state.
- `clear_err`=1 clears both sticky flags at the next edge. If an error condition occurs in the same cycle, the set wins.
- Flags `empty`/`full` are decoded from `count`.

## Timing
- Reset (`reset`=0, asynchronous): `wp`=0, `count`=0, `overflow`=0, `underflow`=0.
  - Outputs during and after reset: `empty`=1, `full`=0, `top_addr`=0.
  - Storage is not reset; the empty gating hides it.
- Deassertion of reset takes effect at the first rising edge where `reset`=1.
- Latency: an operation committed at edge N is visible on `top_addr`/`count`/flags immediately after edge N, i.e. during cycle N+1.
- A RET in the same instruction reads `top_addr` before its own pop commits. The PC mux samples `top_addr` in the commit cycle, so the pre-pop value is used.
- Reset asserted mid-instruction discards any pending push/pop. No partial update is permitted.
- Back-to-back commits on consecutive cycles must be supported, even though the core commits every 5 cycles.
- `wp` wrap-around: DEPTH-1 → 0 on push and 0 → DEPTH-1 on pop.

## Structure
- Shared package `musa_pkg`:
  - `ADDR_WIDTH` default.
  - Opcode constants `OP_CALL`=6'b000011 and `OP_RET`=6'b000001.
  - Stack operation encoding (NONE/PUSH/POP/REPLACE) as a 2-bit enum, decoded inside the block from {push,pop}.
- One sub-module, `return_stack_mem`: DEPTH×ADDR_WIDTH register array with one synchronous write port and one asynchronous read port, no reset.
- Pointer, count and flag logic live in the top module.

## Test plan
- Reset, then 3 commits with push=1 and push_addr=0x10, 0x20, 0x30 → count=3, top_addr=0x30, empty=0, full=0, overflow=0.
- From that state, 2 pop commits → top_addr=0x20 after the first, 0x10 after the second, count=1. A third pop → empty=1, top_addr=0; a fourth pop → underflow=1, count stays 0.
- DEPTH=4: push 0x1..0x5 → full=1, count=4, overflow=1. Then 4 pops yield 0x5, 0x4, 0x3, 0x2, since 0x1 was overwritten.
- Push 0xA, then commit with push=1, pop=1, push_addr=0xB → count=1, top_addr=0xB. The same op on an empty stack → count=1, top_addr=0xB, underflow=1.
- push=1 held for 5 cycles with commit pulsed once → exactly one entry added. push=1 with commit=0 → no change.
- Assert reset=0 asynchronously between edges with count=2 → immediately count=0, empty=1, top_addr=0, flags=0. Set overflow, pulse clear_err → overflow=0 next cycle.

Source files
------------

// File: rtl/musa_pkg.sv
// Shared definitions for the MUSA core: address width, control opcodes and
// the return-stack operation encoding.
package musa_pkg;

    localparam int ADDR_WIDTH = 32;

    localparam logic [5:0] OP_CALL = 6'b000011;
    localparam logic [5:0] OP_RET  = 6'b000001;

    typedef enum logic [1:0] {
        STK_NONE    = 2'b00,
        STK_PUSH    = 2'b01,
        STK_POP     = 2'b10,
        STK_REPLACE = 2'b11
    } stack_op_e;

    // Push and pop together means a tail call: the top entry is replaced.
    function automatic stack_op_e decode_op(input logic push, input logic pop);
        stack_op_e op;
        case ({push, pop})
            2'b10:   op = STK_PUSH;
            2'b01:   op = STK_POP;
            2'b11:   op = STK_REPLACE;
            default: op = STK_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/return_stack_mem.sv
// Return-stack storage: one synchronous write port, one asynchronous read
// port, deliberately without reset (empty gating in the top hides stale data).
module return_stack_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [PTR_W-1:0]      waddr_i,
    input  logic [ADDR_WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0]      raddr_i,
    output logic [ADDR_WIDTH-1:0] rdata_o
);

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_addr_stack.sv
// Circular return-address stack driven by CALL/RET decode; operations take
// effect only on the commit strobe, with sticky overflow/underflow flags.
module return_addr_stack #(
    parameter int ADDR_WIDTH = musa_pkg::ADDR_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  commit,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic                  clear_err,
    output logic [ADDR_WIDTH-1:0] top_addr,
    output logic                  empty,
    output logic                  full,
    output logic [$clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow
);

    import musa_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      wp_q, wp_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  we_s;
    logic [PTR_W-1:0]      waddr_s;
    logic [PTR_W-1:0]      top_ptr_s;
    logic [ADDR_WIDTH-1:0] rdata_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  set_ovf_s;
    logic                  set_unf_s;
    stack_op_e             op_s;

    assign empty_s   = (count_q == {CNT_W{1'b0}});
    assign full_s    = (count_q == CNT_FULL);
    assign top_ptr_s = wp_q - PTR_ONE;

    // Next-state decode for pointer, count, write port and error flags
    always_comb begin
        wp_d      = wp_q;
        count_d   = count_q;
        we_s      = 1'b0;
        waddr_s   = wp_q;
        set_ovf_s = 1'b0;
        set_unf_s = 1'b0;
        op_s      = STK_NONE;
        if (commit) begin
            op_s = decode_op(push, pop);
        end else begin
            op_s = STK_NONE;
        end
        case (op_s)
            STK_PUSH: begin
                we_s = 1'b1;
                wp_d = wp_q + PTR_ONE;
                if (full_s) begin
                    set_ovf_s = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            STK_POP: begin
                if (empty_s) begin
                    set_unf_s = 1'b1;
                end else begin
                    wp_d    = wp_q - PTR_ONE;
                    count_d = count_q - CNT_ONE;
                end
            end
            STK_REPLACE: begin
                we_s = 1'b1;
                // On an empty stack there is no top to replace, so it degrades to a push.
                if (empty_s) begin
                    wp_d      = wp_q + PTR_ONE;
                    count_d   = count_q + CNT_ONE;
                    set_unf_s = 1'b1;
                end else begin
                    waddr_s = top_ptr_s;
                end
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
        overflow_d  = set_ovf_s | (overflow_q & ~clear_err);
        underflow_d = set_unf_s | (underflow_q & ~clear_err);
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q        <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    return_stack_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (we_s),
        .waddr_i (waddr_s),
        .wdata_i (push_addr),
        .raddr_i (top_ptr_s),
        .rdata_o (rdata_s)
    );

    assign top_addr  = empty_s ? {ADDR_WIDTH{1'b0}} : rdata_s;
    assign empty     = empty_s;
    assign full      = full_s;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
